// File: rtl/ir_filter.sv
`default_nettype none
// ============================================================================
// Module   : ir_filter
// Purpose  : Per-channel 2^DEPTH_LOG2-frame boxcar average and obstacle
//            detector for the four 12-bit IR channels from ADC_interface.
//            A frame is snapshotted on ADC_valid and the four channels are
//            updated one per cycle (CH0..CH3), then published in DONE.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            ADC_DATA[3:0]       - raw 12-bit samples, one word per channel
//            ADC_valid           - one-cycle new-frame strobe
//            IR_FILT[3:0]        - filtered value per channel
//            IR_obstacle[3:0]    - obstacle flag per channel
//            IR_valid            - one-cycle pulse when outputs updated
//            IR_primed           - sticky, first full window accepted
//            IR_overrun          - sticky, a frame was dropped
// Config   : IR_FILTER_HYST_EN   - defined: obstacle flag uses hysteresis
//                                  (set >= THRESH, clear < THRESH-HYST)
// Revision : 1.0 - initial release
// ============================================================================
module ir_filter #(
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [11:0] THRESH     = 12'h800,
    parameter logic [11:0] HYST       = 12'h040
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0][11:0] ADC_DATA,
    input  logic             ADC_valid,
    output logic [3:0][11:0] IR_FILT,
    output logic [3:0]       IR_obstacle,
    output logic             IR_valid,
    output logic             IR_primed,
    output logic             IR_overrun
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_SW    = 12 + DEPTH_LOG2;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_CH0  = 3'd1;
    localparam logic [2:0] c_S_CH1  = 3'd2;
    localparam logic [2:0] c_S_CH2  = 3'd3;
    localparam logic [2:0] c_S_CH3  = 3'd4;
    localparam logic [2:0] c_S_DONE = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [3:0][11:0]      r_snap;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [3:0][11:0]      w_avg;
    logic [3:0]            w_obs_next;
    logic [3:0][11:0]      r_filt;
    logic [3:0]            r_obs;
    logic                  r_valid;
    logic                  r_primed;
    logic                  r_overrun;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (ADC_valid) w_state_next = c_S_CH0;
            c_S_CH0:  w_state_next = c_S_CH1;
            c_S_CH1:  w_state_next = c_S_CH2;
            c_S_CH2:  w_state_next = c_S_CH3;
            c_S_CH3:  w_state_next = c_S_DONE;
            c_S_DONE: w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel buffer and running sum. Channel n is updated in CHn.
    // The modular add/subtract is exact because the final sum always fits.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        localparam logic [2:0] c_MY_STATE = 3'(c_S_CH0 + 3'(gi));

        logic [c_SW-1:0] r_sum;
        logic [11:0]     r_buf [c_DEPTH];
        logic [c_SW-1:0] w_new_sum;
        logic [c_SW-1:0] w_final_sum;

        assign w_new_sum = r_sum + c_SW'(r_snap[gi]) - c_SW'(r_buf[r_wr_ptr]);

        // Outputs are latched on the CH3 edge so they appear together with
        // IR_valid in DONE; channel 3's sum is still being written then,
        // so its freshly computed value is used directly.
        if (gi == 3) begin : g_last
            assign w_final_sum = w_new_sum;
        end else begin : g_prev
            assign w_final_sum = r_sum;
        end

        assign w_avg[gi] = w_final_sum[DEPTH_LOG2 +: 12];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sum <= '0;
                for (int i = 0; i < c_DEPTH; i++) begin
                    r_buf[i] <= '0;
                end
            end else if (r_state == c_MY_STATE) begin
                r_sum           <= w_new_sum;
                r_buf[r_wr_ptr] <= r_snap[gi];
            end
        end
    end

    // ------------------------------------------------------------------
    // Obstacle flag
    // ------------------------------------------------------------------
`ifdef IR_FILTER_HYST_EN
    localparam logic [11:0] c_CLR_LEVEL = THRESH - HYST;

    always_comb begin
        w_obs_next = r_obs;
        for (int n = 0; n < 4; n++) begin
            if (w_avg[n] >= THRESH) begin
                w_obs_next[n] = 1'b1;
            end else if (w_avg[n] < c_CLR_LEVEL) begin
                w_obs_next[n] = 1'b0;
            end
        end
    end
`else
    logic w_hyst_unused;
    assign w_hyst_unused = ^HYST;

    always_comb begin
        w_obs_next = '0;
        for (int n = 0; n < 4; n++) begin
            w_obs_next[n] = (w_avg[n] >= THRESH);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_snap    <= '0;
            r_wr_ptr  <= '0;
            r_filt    <= '0;
            r_obs     <= '0;
            r_valid   <= 1'b0;
            r_primed  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= (r_state == c_S_CH3);
            if (ADC_valid) begin
                if (r_state == c_S_IDLE) begin
                    r_snap <= ADC_DATA;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (r_state == c_S_CH3) begin
                r_filt <= w_avg;
                r_obs  <= w_obs_next;
                // wr_ptr has advanced once per earlier frame, so all-ones
                // marks the frame that completes the first window.
                if (&r_wr_ptr) begin
                    r_primed <= 1'b1;
                end
            end
            if (r_state == c_S_DONE) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
        end
    end

    assign IR_FILT     = r_filt;
    assign IR_obstacle = r_obs;
    assign IR_valid    = r_valid;
    assign IR_primed   = r_primed;
    assign IR_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ir_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_filter
// Purpose  : Self-checking bench for ir_filter with a frame scoreboard.
//            Expected averages come from a reference boxcar model that
//            re-sums the last four samples of each channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_filter;

    localparam logic [11:0] c_THRESH = 12'h800;
    localparam logic [11:0] c_HYST   = 12'h040;
    localparam int          c_WIN    = 4;

    typedef struct {
        logic [3:0][11:0] filt;
        logic [3:0]       obs;
        logic             primed;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [3:0][11:0] adc_data;
    logic             adc_valid;
    logic [3:0][11:0] ir_filt;
    logic [3:0]       ir_obstacle;
    logic             ir_valid;
    logic             ir_primed;
    logic             ir_overrun;

    int               n_checks;
    int               n_errors;
    int               cyc;
    exp_t             sb [$];

    logic [11:0]      m_hist [4][c_WIN];
    int               m_idx;
    int               m_frames;
    logic [3:0]       m_obs;
    logic [3:0][11:0] m_last_filt;
    logic [3:0]       m_last_obs;

    ir_filter #(
        .DEPTH_LOG2 (2),
        .THRESH     (c_THRESH),
        .HYST       (c_HYST)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .ADC_DATA    (adc_data),
        .ADC_valid   (adc_valid),
        .IR_FILT     (ir_filt),
        .IR_obstacle (ir_obstacle),
        .IR_valid    (ir_valid),
        .IR_primed   (ir_primed),
        .IR_overrun  (ir_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < c_WIN; k++)
                m_hist[c][k] = '0;
        m_idx       = 0;
        m_frames    = 0;
        m_obs       = '0;
        m_last_filt = '0;
        m_last_obs  = '0;
        sb.delete();
    endfunction

    function automatic void model_push(input logic [3:0][11:0] d, input int c0);
        exp_t e;
        int   sum;
        for (int c = 0; c < 4; c++) begin
            m_hist[c][m_idx] = d[c];
            sum = 0;
            for (int k = 0; k < c_WIN; k++) sum += int'(m_hist[c][k]);
            e.filt[c] = 12'(sum / c_WIN);
`ifdef IR_FILTER_HYST_EN
            if (e.filt[c] >= c_THRESH) m_obs[c] = 1'b1;
            else if (e.filt[c] < c_THRESH - c_HYST) m_obs[c] = 1'b0;
`else
            m_obs[c] = (e.filt[c] >= c_THRESH);
`endif
        end
        m_idx    = (m_idx + 1) % c_WIN;
        m_frames++;
        e.obs    = m_obs;
        e.primed = (m_frames >= c_WIN);
        e.cyc    = c0;
        sb.push_back(e);
    endfunction

    // Output monitor: pops one expectation per IR_valid and checks that the
    // outputs hold their last published value on every other cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (ir_valid) begin
                if (sb.size() == 0) begin
                    check_val("spurious_valid", 64'(ir_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("filt",    64'(ir_filt),     64'(e.filt));
                    check_val("obs",     64'(ir_obstacle), 64'(e.obs));
                    check_val("primed",  64'(ir_primed),   64'(e.primed));
                    check_val("latency", 64'(cyc - e.cyc), 64'd5);
                    m_last_filt = e.filt;
                    m_last_obs  = e.obs;
                end
            end else begin
                check_val("stable_filt", 64'(ir_filt),     64'(m_last_filt));
                check_val("stable_obs",  64'(ir_obstacle), 64'(m_last_obs));
            end
        end
    end

    task automatic pulse(input logic [3:0][11:0] d, input bit push);
        @(posedge clk) #1;
        adc_data  = d;
        adc_valid = 1'b1;
        if (push) model_push(d, cyc);
        @(posedge clk) #1;
        adc_valid = 1'b0;
    endtask

    // One accepted frame; the next pulse lands in the cycle after DONE.
    task automatic send_frame(input logic [3:0][11:0] d);
        pulse(d, 1'b1);
        repeat (4) @(posedge clk);
    endtask

    task automatic send_all(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) send_frame({v, v, v, v});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check_val("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk) #1;
        reset = 1'b1;
        model_clear();
        @(posedge clk) #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_filt"},    64'(ir_filt),     64'd0);
        check_val({tag, "_obs"},     64'(ir_obstacle), 64'd0);
        check_val({tag, "_valid"},   64'(ir_valid),    64'd0);
        check_val({tag, "_primed"},  64'(ir_primed),   64'd0);
        check_val({tag, "_overrun"}, 64'(ir_overrun),  64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        reset     = 1'b1;
        adc_valid = 1'b0;
        adc_data  = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");

        // Ramp and priming
        send_all(12'h400, 4);
        wait_drain();
        check_val("ramp_final", 64'(ir_filt[2]), 64'h400);

        // Saturation then drain to zero through the wrapped pointer
        do_reset();
        for (int i = 0; i < 6; i++) send_frame({12'h0, 12'h0, 12'h0, 12'hFFF});
        wait_drain();
        check_val("sat_ch0", 64'(ir_filt[0]), 64'hFFF);
        send_all(12'h000, 4);
        wait_drain();
        check_val("drain_ch0", 64'(ir_filt[0]), 64'h0);

        // Hysteresis: filtered 800 -> 7D0 -> 7BF
        do_reset();
        send_all(12'h800, 4);
        wait_drain();
        check_val("hyst_800", 64'(ir_obstacle[0]), 64'd1);
        send_all(12'h740, 1);
        wait_drain();
        check_val("hyst_7d0_val", 64'(ir_filt[0]), 64'h7D0);
`ifdef IR_FILTER_HYST_EN
        check_val("hyst_7d0_obs", 64'(ir_obstacle[0]), 64'd1);
`else
        check_val("hyst_7d0_obs", 64'(ir_obstacle[0]), 64'd0);
`endif
        send_all(12'h7BC, 1);
        wait_drain();
        check_val("hyst_7bf_val", 64'(ir_filt[0]), 64'h7BF);
        check_val("hyst_7bf_obs", 64'(ir_obstacle[0]), 64'd0);

        // Overrun: second pulse two cycles after the first is dropped
        do_reset();
        pulse({12'h111, 12'h222, 12'h333, 12'h444}, 1'b1);
        pulse({12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 1'b0);
        wait_drain();
        check_val("ovr_set", 64'(ir_overrun), 64'd1);
        send_all(12'h100, 1);
        wait_drain();
        check_val("ovr_sticky", 64'(ir_overrun), 64'd1);
        do_reset();
        @(negedge clk);
        check_val("ovr_cleared", 64'(ir_overrun), 64'd0);
        // A pulse landing in the DONE cycle is also an overrun
        pulse({12'h010, 12'h020, 12'h030, 12'h040}, 1'b1);
        repeat (3) @(posedge clk);
        pulse({12'hEEE, 12'hEEE, 12'hEEE, 12'hEEE}, 1'b0);
        wait_drain();
        check_val("ovr_done", 64'(ir_overrun), 64'd1);

        // Reset asserted while the FSM is in CH2
        do_reset();
        send_all(12'h400, 2);
        wait_drain();
        pulse({12'h800, 12'h800, 12'h800, 12'h800}, 1'b1);
        @(posedge clk);
        @(posedge clk) #1;
        reset = 1'b1;
        model_clear();
        #1;
        check_reset_outputs("midrst");
        @(posedge clk) #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        send_all(12'h400, 1);
        wait_drain();
        check_val("midrst_next", 64'(ir_filt[1]), 64'h100);

        // Channel independence
        do_reset();
        for (int i = 0; i < 4; i++) send_frame({12'h9AB, 12'h567, 12'h123, 12'hABC});
        wait_drain();
        check_val("indep_filt", 64'(ir_filt),
                  64'({12'h9AB, 12'h567, 12'h123, 12'hABC}));
        check_val("indep_obs", 64'(ir_obstacle), 64'(4'b1001));
        check_val("indep_primed", 64'(ir_primed), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
